// File: rtl/simon_ser_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | simon_ser_pkg : shared types, constants and CRC-8 step for the serialiser |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package simon_ser_pkg;

  localparam int         PKT_BYTES_DEF = 34;
  localparam logic [7:0] CRC_POLY      = 8'h07;

  typedef logic [PKT_BYTES_DEF-1:0][7:0] pkt_t;

  typedef enum logic [0:0] {CAP_IDLE, CAP_ACK} cap_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_CRC} tx_state_t;

  // One byte of MSB-first CRC-8, init supplied by caller.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] data_in);
    logic [7:0] c;
    c = crc_in ^ data_in;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/simon_pkt_slot_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | simon_pkt_slot_buf : two-slot packet register file, byte read port       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module simon_pkt_slot_buf
  import simon_ser_pkg::*;
#(
  parameter int PKT_BYTES = PKT_BYTES_DEF,
  parameter int IDX_W     = 6
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic                      wr_ptr,
  input  logic [PKT_BYTES-1:0][7:0] wr_pkt,
  input  logic                      rd_ptr,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic [7:0]                rd_byte
);

  logic [1:0][PKT_BYTES-1:0][7:0] slot_q;
  logic [1:0][PKT_BYTES-1:0][7:0] slot_d;

  always_comb begin
    slot_d = slot_q;
    if (wr_en) begin
      slot_d[wr_ptr] = wr_pkt;
    end
  end

  // Payload storage carries no reset: a slot is only read after it is written.
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  assign rd_byte = slot_q[rd_ptr][rd_idx];

endmodule
`default_nettype wire

// File: rtl/simon_pkt_serialiser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | simon_pkt_serialiser : ping-pong packet capture, byte-wise TX streaming  |
// | Optional trailing CRC-8 byte when SIMON_SER_CRC_EN is defined. Rev 1.0    |
// +--------------------------------------------------------------------------+
module simon_pkt_serialiser
  import simon_ser_pkg::*;
#(
  parameter int PKT_BYTES = PKT_BYTES_DEF,
  parameter int DEPTH     = 2
) (
  input  logic                      clk,
  input  logic                      R,
  input  logic [PKT_BYTES-1:0][7:0] pkt_in,
  input  logic                      pkt_done,
  output logic                      pkt_read,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      tx_last,
  output logic                      full,
  output logic [1:0]                pkt_count
);

  localparam int               IDX_W    = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);
`ifndef SIMON_SER_CRC_EN
  localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(PKT_BYTES - 2);
`endif

  generate
    if (DEPTH != 2 || PKT_BYTES < 2) begin : g_bad_cfg
      $error("simon_pkt_serialiser: DEPTH must be 2 and PKT_BYTES >= 2");
    end
  endgenerate

  cap_state_t       cap_state_q, cap_state_d;
  tx_state_t        tx_state_q, tx_state_d;
  logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             pkt_read_q, pkt_read_d;
  logic             tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       count_q, count_d;
  logic             full_q, full_d;
  logic             wr_en, free, accept, end_packet;
  logic             rd_ptr_a;
  logic [IDX_W-1:0] rd_idx_a;
  logic [7:0]       rd_byte;
`ifdef SIMON_SER_CRC_EN
  logic [7:0]       crc_q, crc_d;
`endif

  simon_pkt_slot_buf #(.PKT_BYTES(PKT_BYTES), .IDX_W(IDX_W)) u_slot_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_ptr  (wr_ptr_q),
    .wr_pkt  (pkt_in),
    .rd_ptr  (rd_ptr_a),
    .rd_idx  (rd_idx_a),
    .rd_byte (rd_byte)
  );

  assign accept = tx_valid_q && tx_ready;

  // Read address points at the byte that would be presented after the next accept.
  always_comb begin
    rd_ptr_a = rd_ptr_q;
    rd_idx_a = '0;
    if (tx_state_q != TX_IDLE) begin
      if (tx_state_q == TX_CRC || idx_q == LAST_IDX) begin
        rd_ptr_a = ~rd_ptr_q;
      end else begin
        rd_idx_a = idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    tx_data_d  = tx_data_q;
    idx_d      = idx_q;
    rd_ptr_d   = rd_ptr_q;
    free       = 1'b0;
    end_packet = 1'b0;
`ifdef SIMON_SER_CRC_EN
    crc_d      = crc_q;
`endif
    case (tx_state_q)
      TX_IDLE: begin
        if (count_q != 2'd0) begin
          tx_state_d = TX_SEND;
          tx_valid_d = 1'b1;
          tx_last_d  = 1'b0;
          tx_data_d  = rd_byte;
          idx_d      = '0;
`ifdef SIMON_SER_CRC_EN
          crc_d      = 8'h00;
`endif
        end
      end
      TX_SEND: begin
        if (accept) begin
`ifdef SIMON_SER_CRC_EN
          crc_d = crc8_step(crc_q, tx_data_q);
`endif
          if (idx_q == LAST_IDX) begin
`ifdef SIMON_SER_CRC_EN
            tx_state_d = TX_CRC;
            tx_data_d  = crc8_step(crc_q, tx_data_q);
            tx_last_d  = 1'b1;
`else
            end_packet = 1'b1;
`endif
          end else begin
            idx_d     = idx_q + 1'b1;
            tx_data_d = rd_byte;
`ifndef SIMON_SER_CRC_EN
            tx_last_d = (idx_q == PENULT_IDX);
`endif
          end
        end
      end
      TX_CRC: begin
        if (accept) begin
          end_packet = 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // A second slot already held before this edge lets byte 0 follow without a bubble.
    if (end_packet) begin
      free     = 1'b1;
      rd_ptr_d = ~rd_ptr_q;
      if (count_q == 2'd2) begin
        tx_state_d = TX_SEND;
        tx_data_d  = rd_byte;
        tx_last_d  = 1'b0;
        idx_d      = '0;
`ifdef SIMON_SER_CRC_EN
        crc_d      = 8'h00;
`endif
      end else begin
        tx_state_d = TX_IDLE;
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
      end
    end
  end

  // A slot being freed on this edge may be refilled on the same edge.
  always_comb begin
    cap_state_d = cap_state_q;
    pkt_read_d  = pkt_read_q;
    wr_ptr_d    = wr_ptr_q;
    wr_en       = 1'b0;
    case (cap_state_q)
      CAP_IDLE: begin
        if (pkt_done && (count_q != 2'd2 || free)) begin
          wr_en       = 1'b1;
          pkt_read_d  = 1'b1;
          cap_state_d = CAP_ACK;
        end
      end
      CAP_ACK: begin
        if (!pkt_done) begin
          pkt_read_d  = 1'b0;
          wr_ptr_d    = ~wr_ptr_q;
          cap_state_d = CAP_IDLE;
        end
      end
      default: cap_state_d = CAP_IDLE;
    endcase
  end

  assign count_d = count_q + {1'b0, wr_en} - {1'b0, free};
  assign full_d  = (count_d == 2'd2);

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      cap_state_q <= CAP_IDLE;
      tx_state_q  <= TX_IDLE;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      pkt_read_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
      tx_data_q   <= 8'h00;
      idx_q       <= '0;
      count_q     <= 2'd0;
      full_q      <= 1'b0;
    end else begin
      cap_state_q <= cap_state_d;
      tx_state_q  <= tx_state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_read_q  <= pkt_read_d;
      tx_valid_q  <= tx_valid_d;
      tx_last_q   <= tx_last_d;
      tx_data_q   <= tx_data_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      full_q      <= full_d;
    end
  end

`ifdef SIMON_SER_CRC_EN
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end
`endif

  assign pkt_read  = pkt_read_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign tx_last   = tx_last_q;
  assign full      = full_q;
  assign pkt_count = count_q;

endmodule
`default_nettype wire
